mem_resp: RTL and testbench

MEM_RESP -- requirements
Module: mem_resp

---
 rtl/mem_resp_pkg.sv | 23 ++
 rtl/mem_resp_array.sv | 54 +++++
 rtl/mem_resp.sv | 150 +++++++++++++++
 tb/tb_mem_resp.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// ----------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the mem_resp slice: the controller state encoding,
// the default latency and array depth, and the width of the latency counter.
// No ports (package).
// ----------------------------------------------------------------------------
package mem_resp_pkg;

  // Controller states: waiting for a request, counting down latency,
  // and the single completion cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LATENCY_DEFAULT    = 3;
  localparam int DEPTH_LOG2_DEFAULT = 9;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_resp_array.sv
// ----------------------------------------------------------------------------
// mem_resp_array
// 2^DEPTH_LOG2 x 16 storage with one synchronous write port and one
// registered read port. Both ports share a single word index because the
// controller only ever performs one access at a time.
//
// Ports:
//   i_clk    - clock, all updates on the rising edge
//   i_rst    - asynchronous active-high reset, clears only the read register
//   i_we     - write enable, stores i_wdata at i_addr
//   i_re     - read enable, loads o_rdata from i_addr
//   i_addr   - word index
//   i_wdata  - write data
//   o_rdata  - registered read data, held between reads
// ----------------------------------------------------------------------------
module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [15:0]           i_wdata,
  output logic [15:0]           o_rdata
);

  logic [15:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [15:0] r_rdata;

  // The storage itself is deliberately left out of reset: contents survive
  // a reset, and only an in-flight write is lost (the controller simply never
  // raises i_we for it).
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read data register. It is the visible data output of the block, so it
  // clears on reset and otherwise changes only when a read completes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= 16'h0000;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_resp.sv
// ----------------------------------------------------------------------------
// mem_resp
// Fixed-latency memory responder. A single read or write request is captured
// in IDLE, the block stays busy for LATENCY-1 further cycles, performs the
// array access on the edge into DONE, and signals completion for one cycle.
// Malformed requests (both rd and wr, or an odd byte address) are rejected
// with a one-cycle error pulse and never touch the array.
//
// Ports:
//   i_clk      - clock
//   i_rst      - asynchronous active-high reset
//   i_rd       - read request (sampled only in IDLE)
//   i_wr       - write request (sampled only in IDLE)
//   i_addr     - byte address, word index is i_addr[DEPTH_LOG2:1]
//   i_data_in  - write data
//   o_data_out - read data, valid with o_done and held afterwards
//   o_stall    - high while a request is in progress
//   o_done     - one-cycle completion pulse
//   o_err      - one-cycle pulse for a rejected request
// ----------------------------------------------------------------------------
module mem_resp
  import mem_resp_pkg::*;
#(
  parameter int LATENCY    = LATENCY_DEFAULT,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic [15:0] i_addr,
  input  logic [15:0] i_data_in,
  output logic [15:0] o_data_out,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_err
);

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_is_wr;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic [15:0]             r_wdata;
  logic                    r_stall;
  logic                    r_done;
  logic                    r_err;

  logic                    w_req;
  logic                    w_valid;
  logic                    w_capture;
  logic                    w_access;
  logic                    w_err_next;
  logic [DEPTH_LOG2-1:0]   w_idx;
  logic                    w_unused_addr_bits;

  // A request is well formed when exactly one of rd/wr is set and the byte
  // address is word aligned. Upper address bits simply fall off the index,
  // which gives the modulo aliasing of the address space.
  assign w_req   = i_rd | i_wr;
  assign w_valid = (i_rd ^ i_wr) & ~i_addr[0];
  assign w_idx   = i_addr[DEPTH_LOG2:1];

  // The high address bits are intentionally ignored.
  assign w_unused_addr_bits = ^i_addr;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. The array access is issued on the same edge that moves
  // BUSY into DONE, so the read data register is loaded exactly as done rises.
  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_access   = 1'b0;
    w_err_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_next    = BUSY;
          w_capture = 1'b1;
        end else if (w_req) begin
          w_err_next = 1'b1;
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_next   = DONE;
          w_access = 1'b1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Request capture, latency countdown and the registered status flags.
  // The flags are computed from the next state so that they line up exactly
  // with the state register while still coming straight out of flops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_is_wr <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 16'h0000;
      r_stall <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_stall <= (w_next == BUSY);
      r_done  <= (w_next == DONE);
      r_err   <= w_err_next;
      if (w_capture) begin
        r_cnt   <= CNT_W'(LATENCY - 1);
        r_is_wr <= i_wr;
        r_idx   <= w_idx;
        r_wdata <= i_data_in;
      end else if ((r_state == BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  mem_resp_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_access & r_is_wr),
    .i_re    (w_access & ~r_is_wr),
    .i_addr  (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (o_data_out)
  );

  assign o_stall = r_stall;
  assign o_done  = r_done;
  assign o_err   = r_err;

endmodule

// File: tb/tb_mem_resp.sv
// ----------------------------------------------------------------------------
// tb_mem_resp
// Directed bench for mem_resp with the default LATENCY=3 / DEPTH_LOG2=9.
// Inputs change 1ns after a rising edge; outputs are sampled at that point.
// ----------------------------------------------------------------------------
module tb_mem_resp;

  localparam int LATENCY = 3;

  logic        clk;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] dataIn;
  logic [15:0] dataOut;
  logic        stall;
  logic        done;
  logic        err;

  int vectorCount;
  int missCount;
  logic [15:0] lastRead;

  mem_resp dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rd       (rd),
    .i_wr       (wr),
    .i_addr     (addr),
    .i_data_in  (dataIn),
    .o_data_out (dataOut),
    .o_stall    (stall),
    .o_done     (done),
    .o_err      (err)
  );

  // 10ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports miscompares.
  task automatic checkOutput(input string tag, input logic [15:0] got,
                             input logic [15:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Present a request for exactly one clock edge, then withdraw it.
  task automatic applyStimulus(input logic r, input logic w,
                               input logic [15:0] a, input logic [15:0] d);
    rd = r; wr = w; addr = a; dataIn = d;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  // Follow an accepted request from capture through the done pulse.
  task automatic finishAccess(input string tag, input logic isRead,
                              input logic [15:0] expData);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      checkOutput({tag, "_stall"}, {15'd0, stall}, 16'd1);
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput({tag, "_latency"}, cyc[15:0], 16'(LATENCY));
    checkOutput({tag, "_stallLow"}, {15'd0, stall}, 16'd0);
    checkOutput({tag, "_err"}, {15'd0, err}, 16'd0);
    if (isRead) begin
      checkOutput({tag, "_data"}, dataOut, expData);
      lastRead = expData;
    end else begin
      checkOutput({tag, "_dataKept"}, dataOut, lastRead);
    end
    @(posedge clk); #1;
    checkOutput({tag, "_doneFall"}, {15'd0, done}, 16'd0);
    checkOutput({tag, "_hold"}, dataOut, lastRead);
  endtask

  task automatic writeWord(input string tag, input logic [15:0] a,
                           input logic [15:0] d);
    applyStimulus(1'b0, 1'b1, a, d);
    finishAccess(tag, 1'b0, 16'h0000);
  endtask

  task automatic readWord(input string tag, input logic [15:0] a,
                          input logic [15:0] exp);
    applyStimulus(1'b1, 1'b0, a, 16'h0000);
    finishAccess(tag, 1'b1, exp);
  endtask

  // A malformed request: one err cycle, no stall, no done, data untouched.
  task automatic errorCase(input string tag, input logic r, input logic w,
                           input logic [15:0] a, input logic [15:0] d);
    applyStimulus(r, w, a, d);
    checkOutput({tag, "_err"}, {15'd0, err}, 16'd1);
    checkOutput({tag, "_stall"}, {15'd0, stall}, 16'd0);
    checkOutput({tag, "_done"}, {15'd0, done}, 16'd0);
    checkOutput({tag, "_data"}, dataOut, lastRead);
    @(posedge clk); #1;
    checkOutput({tag, "_errFall"}, {15'd0, err}, 16'd0);
    checkOutput({tag, "_idle"}, {15'd0, stall}, 16'd0);
  endtask

  initial begin
    int cyc;
    int doneCnt;
    vectorCount = 0;
    missCount   = 0;
    lastRead    = 16'h0000;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0000; dataIn = 16'h0000;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_stall", {15'd0, stall}, 16'd0);
    checkOutput("reset_done", {15'd0, done}, 16'd0);
    checkOutput("reset_err", {15'd0, err}, 16'd0);
    checkOutput("reset_data", dataOut, 16'h0000);
    rst = 1'b0;

    // Basic write then read-back.
    writeWord("wrBeef", 16'h0010, 16'hBEEF);
    readWord("rdBeef", 16'h0010, 16'hBEEF);
    @(posedge clk); #1;
    checkOutput("rdBeef_holdLater", dataOut, 16'hBEEF);

    // Rejected requests leave the array and data_out alone.
    writeWord("wr20", 16'h0020, 16'h5A5A);
    errorCase("rdwrBoth", 1'b1, 1'b1, 16'h0020, 16'hFFFF);
    errorCase("wrOdd", 1'b0, 1'b1, 16'h0021, 16'hDEAD);
    readWord("rd20", 16'h0020, 16'h5A5A);
    errorCase("rdOdd", 1'b1, 1'b0, 16'h0011, 16'h0000);

    // Address aliasing: 0x0410 and 0x0010 are the same word.
    writeWord("wrAlias", 16'h0410, 16'h1234);
    readWord("rdAlias", 16'h0010, 16'h1234);

    // Reset in the middle of a write discards the write.
    writeWord("wr30", 16'h0030, 16'h0F0F);
    applyStimulus(1'b0, 1'b1, 16'h0030, 16'hAAAA);
    checkOutput("rstMid_busy", {15'd0, stall}, 16'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("rstMid_stall", {15'd0, stall}, 16'd0);
    checkOutput("rstMid_done", {15'd0, done}, 16'd0);
    checkOutput("rstMid_data", dataOut, 16'h0000);
    lastRead = 16'h0000;
    @(posedge clk); #1;
    rst = 1'b0;
    readWord("rd30", 16'h0030, 16'h0F0F);

    // A second request held during BUSY must be ignored.
    applyStimulus(1'b0, 1'b1, 16'h0040, 16'h1111);
    wr = 1'b1; addr = 16'h0040; dataIn = 16'h2222;
    cyc = 0;
    doneCnt = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (done === 1'b1) doneCnt++;
    wr = 1'b0;
    checkOutput("ignoreBusy_latency", cyc[15:0], 16'(LATENCY));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) doneCnt++;
    end
    checkOutput("ignoreBusy_doneCnt", doneCnt[15:0], 16'd1);
    readWord("rd40", 16'h0040, 16'h1111);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
